// File: rtl/dictionary_pkg.sv
// ---------------------------------------------------------------------------
// dictionary_pkg
// Shared definitions for the compressed-instruction dictionaries.
//   dict_state_e : dictionary load state (IDLE / LOAD / READY)
//   dict_depth() : number of entries addressable by a key of the given width
// ---------------------------------------------------------------------------
package dictionary_pkg;

  typedef enum logic [1:0] {
    DICT_IDLE  = 2'd0,
    DICT_LOAD  = 2'd1,
    DICT_READY = 2'd2
  } dict_state_e;

  function automatic int dict_depth(input int key_width);
    return 1 << key_width;
  endfunction

endpackage

// File: rtl/dict_priority_match.sv
// ---------------------------------------------------------------------------
// dict_priority_match
// Combinational reverse lookup: compares one value against every dictionary
// entry and reports whether a valid entry holds it, plus the lowest such index.
//   entries_in : all entries, entry i at [i*VAL_WIDTH +: VAL_WIDTH]
//   valid_in   : per-entry valid bits; invalid entries never match
//   value_in   : value to search for
//   hit_out    : at least one valid entry equals value_in
//   idx_out    : lowest matching index, 0 when there is no match
// ---------------------------------------------------------------------------
module dict_priority_match
  import dictionary_pkg::*;
#(
  parameter  int KEY_WIDTH = 4,
  parameter  int VAL_WIDTH = 8,
  localparam int DEPTH     = dict_depth(KEY_WIDTH)
) (
  input  logic [DEPTH*VAL_WIDTH-1:0] entries_in,
  input  logic [DEPTH-1:0]           valid_in,
  input  logic [VAL_WIDTH-1:0]       value_in,
  output logic                       hit_out,
  output logic [KEY_WIDTH-1:0]       idx_out
);

  logic [DEPTH-1:0] eq;

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_cmp
    assign eq[gi] = valid_in[gi] && (entries_in[gi*VAL_WIDTH +: VAL_WIDTH] == value_in);
  end

  // Scan from the top down so the last assignment wins: the lowest index.
  always_comb begin
    hit_out = |eq;
    idx_out = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (eq[i]) begin
        idx_out = KEY_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/multi_port_dictionary.sv
// ---------------------------------------------------------------------------
// multi_port_dictionary
// Loadable dictionary with NUM_PORTS independent lookup channels. Each channel
// returns key->value (decompress) and value->key (compress) results one cycle
// after the request.
//   clk, rst_n                    : clock, synchronous active-low reset
//   load_start                    : clear all entries and (re)enter LOAD
//   load_valid/ready/data/last    : entry load stream, written in index order
//   dict_ready                    : dictionary is in READY
//   entry_count                   : number of valid entries (0..DEPTH)
//   load_overflow                 : sticky, load word offered when none accepted
//   lk_valid_in, key_lookup_in,
//   val_lookup_in                 : per-port lookup requests (packed per port)
//   lk_valid_out, val_out,
//   val_out_hit, key_out,
//   val_lookup_result             : per-port registered lookup responses
// ---------------------------------------------------------------------------
module multi_port_dictionary
  import dictionary_pkg::*;
#(
  parameter int KEY_WIDTH = 4,
  parameter int VAL_WIDTH = 8,
  parameter int NUM_PORTS = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           load_start,
  input  logic                           load_valid,
  output logic                           load_ready,
  input  logic [VAL_WIDTH-1:0]           load_data,
  input  logic                           load_last,
  output logic                           dict_ready,
  output logic [KEY_WIDTH:0]             entry_count,
  output logic                           load_overflow,
  input  logic [NUM_PORTS-1:0]           lk_valid_in,
  input  logic [NUM_PORTS*KEY_WIDTH-1:0] key_lookup_in,
  input  logic [NUM_PORTS*VAL_WIDTH-1:0] val_lookup_in,
  output logic [NUM_PORTS-1:0]           lk_valid_out,
  output logic [NUM_PORTS*VAL_WIDTH-1:0] val_out,
  output logic [NUM_PORTS-1:0]           val_out_hit,
  output logic [NUM_PORTS*KEY_WIDTH-1:0] key_out,
  output logic [NUM_PORTS-1:0]           val_lookup_result
);

  localparam int DEPTH = dict_depth(KEY_WIDTH);
  localparam int CW    = KEY_WIDTH + 1;

  dict_state_e          state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [DEPTH-1:0]     valid_q, valid_d;
  logic                 overflow_q, overflow_d;
  logic [VAL_WIDTH-1:0] mem_q [DEPTH];
  logic [VAL_WIDTH-1:0] mem_d [DEPTH];

  logic [DEPTH*VAL_WIDTH-1:0] mem_flat;
  logic                       load_fire;

  assign load_ready    = (state_q == DICT_LOAD) && (count_q < CW'(DEPTH));
  assign dict_ready    = (state_q == DICT_READY);
  assign entry_count   = count_q;
  assign load_overflow = overflow_q;

  // A load_start in the same cycle drops the offered word.
  assign load_fire = load_valid && load_ready && !load_start;

  // ---------------- load FSM ----------------
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    valid_d    = valid_q;
    overflow_d = overflow_q;
    if (load_start) begin
      state_d    = DICT_LOAD;
      count_d    = '0;
      valid_d    = '0;
      overflow_d = 1'b0;
    end else begin
      // Any word offered while nothing can be accepted is flagged.
      if (load_valid && ((state_q != DICT_LOAD) || (count_q == CW'(DEPTH)))) begin
        overflow_d = 1'b1;
      end
      if (load_fire) begin
        valid_d[count_q[KEY_WIDTH-1:0]] = 1'b1;
        count_d = count_q + CW'(1);
        if (load_last || (count_q == CW'(DEPTH - 1))) begin
          state_d = DICT_READY;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= DICT_IDLE;
      count_q    <= '0;
      valid_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  // ---------------- entry storage ----------------
  // Every entry is read in parallel by the match logic, so storage is flops.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (load_fire && (count_q[KEY_WIDTH-1:0] == KEY_WIDTH'(i))) begin
        mem_d[i] = load_data;
      end
    end
  end

  // Contents are deliberately not reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_flat
    assign mem_flat[gi*VAL_WIDTH +: VAL_WIDTH] = mem_q[gi];
  end

  // ---------------- lookup channels ----------------
  // Lookups read the current (pre-write) contents, so a same-cycle load or
  // load_start is not visible to that request.
  for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
    logic [KEY_WIDTH-1:0] key_in;
    logic [VAL_WIDTH-1:0] val_in;
    logic                 match_hit;
    logic [KEY_WIDTH-1:0] match_idx;
    logic                 lk_valid_q, lk_valid_d;
    logic [VAL_WIDTH-1:0] val_q, val_d;
    logic                 hit_q, hit_d;
    logic [KEY_WIDTH-1:0] key_q, key_d;
    logic                 res_q, res_d;

    assign key_in = key_lookup_in[gi*KEY_WIDTH +: KEY_WIDTH];
    assign val_in = val_lookup_in[gi*VAL_WIDTH +: VAL_WIDTH];

    dict_priority_match #(
      .KEY_WIDTH (KEY_WIDTH),
      .VAL_WIDTH (VAL_WIDTH)
    ) u_match (
      .entries_in (mem_flat),
      .valid_in   (valid_q),
      .value_in   (val_in),
      .hit_out    (match_hit),
      .idx_out    (match_idx)
    );

    // Data outputs hold their last response while no request is present.
    always_comb begin
      lk_valid_d = lk_valid_in[gi];
      val_d      = val_q;
      hit_d      = hit_q;
      key_d      = key_q;
      res_d      = res_q;
      if (lk_valid_in[gi]) begin
        hit_d = valid_q[key_in];
        val_d = valid_q[key_in] ? mem_q[key_in] : '0;
        key_d = match_idx;
        res_d = match_hit;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        lk_valid_q <= 1'b0;
        val_q      <= '0;
        hit_q      <= 1'b0;
        key_q      <= '0;
        res_q      <= 1'b0;
      end else begin
        lk_valid_q <= lk_valid_d;
        val_q      <= val_d;
        hit_q      <= hit_d;
        key_q      <= key_d;
        res_q      <= res_d;
      end
    end

    assign lk_valid_out[gi]                      = lk_valid_q;
    assign val_out[gi*VAL_WIDTH +: VAL_WIDTH]    = val_q;
    assign val_out_hit[gi]                       = hit_q;
    assign key_out[gi*KEY_WIDTH +: KEY_WIDTH]    = key_q;
    assign val_lookup_result[gi]                 = res_q;
  end

endmodule

// File: tb/tb_multi_port_dictionary.sv
// ---------------------------------------------------------------------------
// tb_multi_port_dictionary
// Directed bench for multi_port_dictionary with a behavioural dictionary model
// and a response scoreboard, plus constant checks on the key scenarios.
// ---------------------------------------------------------------------------
module tb_multi_port_dictionary;

  localparam int KW    = 4;
  localparam int VW    = 8;
  localparam int NP    = 2;
  localparam int DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            load_start;
  logic            load_valid;
  logic            load_ready;
  logic [VW-1:0]   load_data;
  logic            load_last;
  logic            dict_ready;
  logic [KW:0]     entry_count;
  logic            load_overflow;
  logic [NP-1:0]   lk_valid_in;
  logic [NP*KW-1:0] key_lookup_in;
  logic [NP*VW-1:0] val_lookup_in;
  logic [NP-1:0]   lk_valid_out;
  logic [NP*VW-1:0] val_out;
  logic [NP-1:0]   val_out_hit;
  logic [NP*KW-1:0] key_out;
  logic [NP-1:0]   val_lookup_result;

  always #5 clk = ~clk;

  multi_port_dictionary #(
    .KEY_WIDTH (KW),
    .VAL_WIDTH (VW),
    .NUM_PORTS (NP)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .load_start        (load_start),
    .load_valid        (load_valid),
    .load_ready        (load_ready),
    .load_data         (load_data),
    .load_last         (load_last),
    .dict_ready        (dict_ready),
    .entry_count       (entry_count),
    .load_overflow     (load_overflow),
    .lk_valid_in       (lk_valid_in),
    .key_lookup_in     (key_lookup_in),
    .val_lookup_in     (val_lookup_in),
    .lk_valid_out      (lk_valid_out),
    .val_out           (val_out),
    .val_out_hit       (val_out_hit),
    .key_out           (key_out),
    .val_lookup_result (val_lookup_result)
  );

  typedef struct {
    int          port;
    logic [VW-1:0] val;
    logic        hit;
    logic [KW-1:0] key;
    logic        res;
  } exp_t;

  exp_t sb[$];
  int vectors     = 0;
  int miscompares = 0;

  // Behavioural dictionary model: 0 = IDLE, 1 = LOAD, 2 = READY
  logic [VW-1:0]    m_mem [DEPTH];
  logic [DEPTH-1:0] m_valid = '0;
  int               m_count = 0;
  int               m_state = 0;
  logic             m_ovf   = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_lookup(input int p);
    exp_t e;
    logic [KW-1:0] k;
    logic [VW-1:0] v;
    k = key_lookup_in[p*KW +: KW];
    v = val_lookup_in[p*VW +: VW];
    e.port = p;
    e.hit  = m_valid[k];
    e.val  = m_valid[k] ? m_mem[k] : '0;
    e.res  = 1'b0;
    e.key  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (m_valid[i] && (m_mem[i] === v)) begin
        e.res = 1'b1;
        e.key = KW'(i);
      end
    end
    return e;
  endfunction

  task automatic model_update();
    if (!rst_n) begin
      m_state = 0;
      m_count = 0;
      m_valid = '0;
      m_ovf   = 1'b0;
    end else if (load_start) begin
      m_state = 1;
      m_count = 0;
      m_valid = '0;
      m_ovf   = 1'b0;
    end else begin
      if (load_valid && (m_state != 1 || m_count == DEPTH)) m_ovf = 1'b1;
      if (load_valid && m_state == 1 && m_count < DEPTH) begin
        m_mem[m_count]   = load_data;
        m_valid[m_count] = 1'b1;
        m_count++;
        if (load_last || m_count == DEPTH) m_state = 2;
      end
    end
  endtask

  // One clock: queue expected responses for requests being presented, advance
  // the model, then compare everything the DUT shows after the edge.
  task automatic tick();
    logic [NP-1:0] req;
    exp_t e;
    if (rst_n) chk("load_ready", {31'd0, load_ready}, {31'd0, (m_state == 1 && m_count < DEPTH)});
    req = rst_n ? lk_valid_in : '0;
    for (int p = 0; p < NP; p++) begin
      if (req[p]) sb.push_back(model_lookup(p));
    end
    model_update();
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("lk_valid_out[%0d]", p), {31'd0, lk_valid_out[p]}, {31'd0, req[p]});
      if (req[p]) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL scoreboard_empty port %0d: observed response expected none queued", p);
        end else begin
          e = sb.pop_front();
          chk($sformatf("val_out[%0d]", e.port), {24'd0, val_out[e.port*VW +: VW]}, {24'd0, e.val});
          chk($sformatf("val_out_hit[%0d]", e.port), {31'd0, val_out_hit[e.port]}, {31'd0, e.hit});
          chk($sformatf("key_out[%0d]", e.port), {28'd0, key_out[e.port*KW +: KW]}, {28'd0, e.key});
          chk($sformatf("val_lookup_result[%0d]", e.port), {31'd0, val_lookup_result[e.port]}, {31'd0, e.res});
        end
      end
    end
    chk("entry_count", {27'd0, entry_count}, m_count);
    chk("dict_ready", {31'd0, dict_ready}, {31'd0, (m_state == 2)});
    chk("load_overflow", {31'd0, load_overflow}, {31'd0, m_ovf});
    lk_valid_in = '0;
    load_valid  = 1'b0;
    load_start  = 1'b0;
    load_last   = 1'b0;
  endtask

  task automatic req(input int p, input logic [KW-1:0] k, input logic [VW-1:0] v);
    lk_valid_in[p]           = 1'b1;
    key_lookup_in[p*KW +: KW] = k;
    val_lookup_in[p*VW +: VW] = v;
  endtask

  task automatic load_word(input logic [VW-1:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    tick();
  endtask

  task automatic start();
    load_start = 1'b1;
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " lk_valid_out"}, {30'd0, lk_valid_out}, 32'd0);
    chk({tag, " val_out"}, {16'd0, val_out}, 32'd0);
    chk({tag, " val_out_hit"}, {30'd0, val_out_hit}, 32'd0);
    chk({tag, " key_out"}, {24'd0, key_out}, 32'd0);
    chk({tag, " val_lookup_result"}, {30'd0, val_lookup_result}, 32'd0);
    chk({tag, " load_ready"}, {31'd0, load_ready}, 32'd0);
    chk({tag, " dict_ready"}, {31'd0, dict_ready}, 32'd0);
    chk({tag, " entry_count"}, {27'd0, entry_count}, 32'd0);
    chk({tag, " load_overflow"}, {31'd0, load_overflow}, 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    load_start    = 1'b0;
    load_valid    = 1'b0;
    load_data     = '0;
    load_last     = 1'b0;
    lk_valid_in   = '0;
    key_lookup_in = '0;
    val_lookup_in = '0;

    // Reset state
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Empty dictionary: nothing hits, not even value 0x00
    req(0, 4'd3, 8'h00);
    req(1, 4'd0, 8'h00);
    tick();
    chk("idle lk_valid_out", {30'd0, lk_valid_out}, 32'd3);
    chk("idle val_out_hit0", {31'd0, val_out_hit[0]}, 32'd0);
    chk("idle val_out0", {24'd0, val_out[7:0]}, 32'd0);
    chk("idle result", {30'd0, val_lookup_result}, 32'd0);

    // Basic load of three words
    start();
    load_word(8'h11, 1'b0);
    load_word(8'h22, 1'b0);
    load_word(8'h33, 1'b1);
    chk("load3 count", {27'd0, entry_count}, 32'd3);
    chk("load3 ready", {31'd0, dict_ready}, 32'd1);
    req(0, 4'd1, 8'h00);
    req(1, 4'd0, 8'h33);
    tick();
    chk("load3 val_out0", {24'd0, val_out[7:0]}, 32'h22);
    chk("load3 hit0", {31'd0, val_out_hit[0]}, 32'd1);
    chk("load3 key_out1", {28'd0, key_out[7:4]}, 32'd2);
    chk("load3 result1", {31'd0, val_lookup_result[1]}, 32'd1);

    // Duplicates: lowest index wins on both ports simultaneously
    start();
    load_word(8'h5A, 1'b0);
    load_word(8'h7F, 1'b0);
    load_word(8'h5A, 1'b1);
    req(0, 4'd2, 8'h5A);
    req(1, 4'd1, 8'h5A);
    tick();
    chk("dup key_out", {24'd0, key_out}, 32'h00);
    chk("dup result", {30'd0, val_lookup_result}, 32'd3);

    // Full load without load_last, then an overflow attempt
    start();
    for (int i = 0; i < DEPTH; i++) begin
      load_word(8'(i * 7 + 3), 1'b0);
    end
    chk("full ready", {31'd0, dict_ready}, 32'd1);
    chk("full count", {27'd0, entry_count}, 32'd16);
    load_valid = 1'b1;
    load_data  = 8'hEE;
    chk("full load_ready", {31'd0, load_ready}, 32'd0);
    tick();
    chk("full overflow", {31'd0, load_overflow}, 32'd1);
    req(0, 4'd15, 8'h6C);
    req(1, 4'd0, 8'h6C);
    tick();
    chk("full val_out15", {24'd0, val_out[7:0]}, 32'h6C);
    chk("full key_out1", {28'd0, key_out[7:4]}, 32'd15);

    // Same-cycle write and lookup sees pre-write contents
    start();
    chk("restart overflow clr", {31'd0, load_overflow}, 32'd0);
    load_word(8'h01, 1'b0);
    load_word(8'h02, 1'b0);
    load_valid = 1'b1;
    load_data  = 8'h44;
    req(0, 4'd0, 8'h44);
    tick();
    chk("wr/rd miss", {31'd0, val_lookup_result[0]}, 32'd0);
    req(0, 4'd0, 8'h44);
    tick();
    chk("wr/rd later hit", {31'd0, val_lookup_result[0]}, 32'd1);
    chk("wr/rd later key", {28'd0, key_out[3:0]}, 32'd2);

    // load_start mid-load beats a same-cycle handshake
    start();
    for (int i = 0; i < 5; i++) begin
      load_word(8'(8'h10 + i), 1'b0);
    end
    chk("mid count5", {27'd0, entry_count}, 32'd5);
    load_start = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'h99;
    tick();
    chk("mid count0", {27'd0, entry_count}, 32'd0);
    req(0, 4'd0, 8'h99);
    tick();
    chk("mid hit0", {31'd0, val_out_hit[0]}, 32'd0);
    chk("mid result0", {31'd0, val_lookup_result[0]}, 32'd0);

    // Reset during LOAD with a lookup pending
    load_word(8'hAB, 1'b0);
    req(0, 4'd0, 8'hAB);
    req(1, 4'd0, 8'hAB);
    rst_n = 1'b0;
    tick();
    chk_all_zero("load reset");
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
